mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_pkg.sv | 15 +
 rtl/mult_div_unit.sv | 94 +++++++++
 tb/tb_mult_div_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared Op/state encodings and default iteration count for mult_div_unit.
package mult_div_pkg;
    localparam int ITER_DEFAULT = 32;
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_FINISH = 2'b10
    } state_e;
endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit, one shift-add or restoring-divide step per cycle.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] BusA,
    input  logic [31:0] BusB,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic        HiWr,
    input  logic        LoWr,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);
    localparam logic [4:0] LAST = 5'(ITER - 1);
    state_e      r_state;
    op_e         r_op;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_a, r_b, r_hi, r_lo;
    logic        r_neg_q, r_neg_a, r_done;
    logic        w_sgn, w_a_neg, w_b_neg, w_div, w_ge;
    logic [31:0] w_a_mag, w_b_mag, w_sub, w_q, w_r, w_fin_hi, w_fin_lo;
    logic [32:0] w_sh, w_add;
    logic [63:0] w_next, w_prod;
    // Signed ops work on magnitudes; signs are reapplied in FINISH.
    assign w_sgn   = ~Op[0];
    assign w_a_neg = w_sgn & BusA[31];
    assign w_b_neg = w_sgn & BusB[31];
    assign w_a_mag = w_a_neg ? -BusA : BusA;
    assign w_b_mag = w_b_neg ? -BusB : BusB;
    assign w_div   = (r_op == OP_DIV) || (r_op == OP_DIVU);
    // Multiply: hi half accumulates, lo half holds the multiplier and shifts out.
    assign w_add   = {1'b0, r_acc[63:32]} + {1'b0, r_acc[0] ? r_b : 32'd0};
    // Divide: hi half is the partial remainder, lo half shifts dividend out and quotient in.
    assign w_sh    = r_acc[63:31];
    assign w_ge    = w_sh >= {1'b0, r_b};
    assign w_sub   = w_sh[31:0] - r_b;
    assign w_next  = w_div ? {(w_ge ? w_sub : w_sh[31:0]), r_acc[30:0], w_ge}
                           : {w_add, r_acc[31:1]};
    assign w_prod  = r_neg_q ? -r_acc : r_acc;
    assign w_q     = r_neg_q ? -r_acc[31:0] : r_acc[31:0];
    assign w_r     = r_neg_a ? -r_acc[63:32] : r_acc[63:32];
    assign w_fin_hi = w_div ? ((r_b == 32'd0) ? r_a : w_r) : w_prod[63:32];
    assign w_fin_lo = w_div ? ((r_b == 32'd0) ? 32'hFFFF_FFFF : w_q) : w_prod[31:0];
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_cnt   <= 5'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (HiWr) r_hi <= BusA;
                    if (LoWr) r_lo <= BusA;
                    if (Start) begin
                        r_op    <= op_e'(Op);
                        r_a     <= BusA;
                        r_b     <= w_b_mag;
                        r_acc   <= {32'd0, w_a_mag};
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_a <= w_a_neg;
                        r_cnt   <= 5'd0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_next;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == LAST) r_state <= S_FINISH;
                end
                S_FINISH: begin
                    r_hi    <= w_fin_hi;
                    r_lo    <= w_fin_lo;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign Busy = r_state != S_IDLE;
    assign Done = r_done;
    assign Hi   = r_hi;
    assign Lo   = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized and directed checks of mult_div_unit against an arithmetic reference model.
module tb_mult_div_unit;
    localparam int ITER = 32;
    logic        Clk = 1'b0, Reset = 1'b1, Start = 1'b0, HiWr = 1'b0, LoWr = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] BusA = 32'd0, BusB = 32'd0;
    logic        Busy, Done;
    logic [31:0] Hi, Lo;
    int checks = 0, failures = 0;
    int m_cnt = 0;
    logic m_done = 1'b0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
    bit chk_on = 1'b0;

    mult_div_unit #(.ITER(ITER)) dut (
        .Clk(Clk), .Reset(Reset), .BusA(BusA), .BusB(BusB), .Start(Start), .Op(Op),
        .HiWr(HiWr), .LoWr(LoWr), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = 32'd0;
        lo = 32'd0;
        case (op)
            2'b00: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            2'b01: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            2'b10: if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
                   else begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
            default: if (b == 32'd0) begin hi = a; lo = 32'hFFFF_FFFF; end
                     else begin hi = a % b; lo = a / b; end
        endcase
    endfunction

    task automatic model_edge();
        if (Reset) begin
            m_cnt = 0; m_done = 1'b0; m_hi = 32'd0; m_lo = 32'd0;
        end else begin
            m_done = 1'b0;
            if (m_cnt == 0) begin
                if (HiWr) m_hi = BusA;
                if (LoWr) m_lo = BusA;
                if (Start) begin
                    ref_op(Op, BusA, BusB, p_hi, p_lo);
                    m_cnt = ITER + 1;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; end
            end
        end
    endtask

    always @(negedge Clk) begin
        if (chk_on) begin
            chk("busy", 64'(Busy), 64'(m_cnt != 0));
            chk("done", 64'(Done), 64'(m_done));
            chk("hi", 64'(Hi), 64'(m_hi));
            chk("lo", 64'(Lo), 64'(m_lo));
        end
    end

    task automatic drive(input logic rst, input logic st, input logic [1:0] op, input logic hw,
                         input logic lw, input logic [31:0] a, input logic [31:0] b);
        Reset = rst; Start = st; Op = op; HiWr = hw; LoWr = lw; BusA = a; BusB = b;
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int lat = 0;
        drive(1'b0, 1'b1, op, 1'b0, 1'b0, a, b);
        while (!Done && lat < 50) begin
            drive(1'b0, 1'b0, 2'($urandom), 1'b0, 1'b0, rnd32(), rnd32());
            lat++;
        end
        chk({name, "_latency"}, 64'(lat), 64'(ITER + 1));
        chk({name, "_hi"}, 64'(Hi), 64'(ehi));
        chk({name, "_lo"}, 64'(Lo), 64'(elo));
    endtask

    initial begin
        logic [31:0] h, l;
        drive(1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 32'h1234_5678, 32'd3);
        chk_on = 1'b1;
        drive(1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 32'h1234_5678, 32'd3);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_hilo", {Hi, Lo}, 64'd0);
        ref_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, h, l); chk("ref_multu", {h, l}, 64'hFFFFFFFE_00000001);
        ref_op(2'b00, 32'hFFFF_FFF9, 32'd3, h, l);        chk("ref_mult", {h, l}, 64'hFFFFFFFF_FFFFFFEB);
        ref_op(2'b10, 32'hFFFF_FFF9, 32'd2, h, l);        chk("ref_div", {h, l}, 64'hFFFFFFFF_FFFFFFFD);
        ref_op(2'b11, 32'd100, 32'd7, h, l);              chk("ref_divu", {h, l}, 64'h00000002_0000000E);
        ref_op(2'b11, 32'd5, 32'd0, h, l);                chk("ref_div0", {h, l}, 64'h00000005_FFFFFFFF);
        ref_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, h, l); chk("ref_ovf", {h, l}, 64'h00000000_80000000);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg", 2'b00, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("divu_zero", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        run_op("div_zero_neg", 2'b10, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF);
        drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 32'hA5A5_A5A5, 32'd0);
        chk("mthi", 64'(Hi), 64'hA5A5_A5A5);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 32'h5A5A_0001, 32'd0);
        chk("mtlo", {Hi, Lo}, 64'hA5A5A5A5_5A5A0001);
        drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 32'hC0DE_0042, 32'd0);
        chk("mthilo", {Hi, Lo}, 64'hC0DE0042_C0DE0042);
        drive(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 32'd9, 32'd4);
        repeat (5) drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'd7);
        chk("busy_wr_ignored", {Hi, Lo}, 64'hC0DE0042_C0DE0042);
        repeat (ITER - 5) drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("busy_start_done", {31'd0, Done, Hi, Lo}, {31'd1, 1'b1, 32'd1, 32'd2});
        run_op("back_to_back", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42);
        drive(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 32'd11, 32'd11);
        chk("start_and_mthi", 64'(Hi), 64'd11);
        repeat (10) drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
        chk("abort_busy", 64'(Busy), 64'd0);
        chk("abort_hilo", {Hi, Lo}, 64'd0);
        repeat (30) drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (6000) drive($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, 2'($urandom),
                            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, rnd32(), rnd32());
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
